// File: rtl/gpio_probe_pkg.sv
// Shared types and constants for the GPIO pin-probe receive path.
package gpio_probe_pkg;

  localparam int GPIO_WIDTH = 36;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BASE   = 3'd1,
    ARMED  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } mon_state_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/gpio_response_monitor_if.sv
// Control/result handshake between the probe control logic (master) and the monitor (slave).
// res_partial is present only when PARTIAL_MASK_EN is defined.
interface gpio_response_monitor_if
  import gpio_probe_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);

  logic             start;
  logic             stim_pulse;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_mask;
  logic             res_overrun;

`ifdef PARTIAL_MASK_EN
  logic [WIDTH-1:0] res_partial;

  modport master (
    output start, stim_pulse, res_ready,
    input  busy, res_valid, res_mask, res_overrun, res_partial
  );

  modport slave (
    input  start, stim_pulse, res_ready,
    output busy, res_valid, res_mask, res_overrun, res_partial
  );
`else
  modport master (
    output start, stim_pulse, res_ready,
    input  busy, res_valid, res_mask, res_overrun
  );

  modport slave (
    input  start, stim_pulse, res_ready,
    output busy, res_valid, res_mask, res_overrun
  );
`endif

endinterface

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer bringing the asynchronous GPIO levels into the clk domain.
module gpio_sync #(
  parameter int WIDTH       = 36,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_response_monitor.sv
// Counts, per GPIO pin, how many probe toggles it followed and reports the consistent followers.
// Optional build macro: PARTIAL_MASK_EN adds the res_partial (intermittent pin) result.
//
// state  | meaning
// IDLE   | waiting for start; last result mask held
// BASE   | settle delay before capturing the baseline levels
// ARMED  | waiting for the next stim_pulse
// SETTLE | settle delay after a stim, then compare and count
// DONE   | result valid until consumed
module gpio_response_monitor
  import gpio_probe_pkg::*;
#(
  parameter int WIDTH         = GPIO_WIDTH,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1000,
  parameter int NUM_STIM      = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH-1:0]        gpio_in,
  gpio_response_monitor_if.slave  mon
);

  localparam int CW = cnt_width(NUM_STIM);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STIM_MAX    = CW'(NUM_STIM);
  localparam logic [CW-1:0] STIM_LAST   = CW'(NUM_STIM - 1);

  mon_state_t               state, state_nxt;
  logic [WIDTH-1:0]         sync;
  logic [WIDTH-1:0]         prev;
  logic [WIDTH-1:0]         diff;
  logic [SW-1:0]            settle_cnt;
  logic [CW-1:0]            stim_cnt;
  logic [WIDTH-1:0][CW-1:0] pin_cnt, pin_cnt_nxt;
  logic [WIDTH-1:0]         mask_q, mask_nxt;
  logic                     overrun_q;
  logic                     settle_zero, last_stim;
  logic                     settle_load, meas_clr, base_take, step_take, overrun_set;

  gpio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (gpio_in),
    .q       (sync)
  );

  assign settle_zero = (settle_cnt == '0);
  assign last_stim   = (stim_cnt == STIM_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    settle_load = 1'b0;
    meas_clr    = 1'b0;
    base_take   = 1'b0;
    step_take   = 1'b0;
    overrun_set = mon.stim_pulse && ((state == BASE) || (state == SETTLE));
    case (state)
      IDLE: begin
        if (mon.start) begin
          state_nxt   = BASE;
          settle_load = 1'b1;
          meas_clr    = 1'b1;
        end
      end
      BASE: begin
        if (settle_zero) begin
          state_nxt = ARMED;
          base_take = 1'b1;
        end
      end
      ARMED: begin
        if (mon.stim_pulse) begin
          state_nxt   = SETTLE;
          settle_load = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_zero) begin
          step_take = 1'b1;
          state_nxt = last_stim ? DONE : ARMED;
        end
      end
      DONE: begin
        if (mon.res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter values after this step; the result is taken from these so DONE
  // already reflects the final comparison.
  always_comb begin
    diff        = sync ^ prev;
    pin_cnt_nxt = pin_cnt;
    mask_nxt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i] && (pin_cnt[i] != STIM_MAX)) begin
        pin_cnt_nxt[i] = pin_cnt[i] + CW'(1);
      end
      mask_nxt[i] = (pin_cnt_nxt[i] == STIM_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
      stim_cnt   <= '0;
      pin_cnt    <= '0;
      prev       <= '0;
      mask_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (settle_load) begin
        settle_cnt <= SETTLE_LOAD;
      end else if (((state == BASE) || (state == SETTLE)) && !settle_zero) begin
        settle_cnt <= settle_cnt - SW'(1);
      end

      if (meas_clr) begin
        stim_cnt  <= '0;
        pin_cnt   <= '0;
        overrun_q <= 1'b0;
      end else if (overrun_set) begin
        overrun_q <= 1'b1;
      end

      if (base_take) begin
        prev <= sync;
      end

      if (step_take) begin
        prev     <= sync;
        pin_cnt  <= pin_cnt_nxt;
        stim_cnt <= stim_cnt + CW'(1);
        if (last_stim) begin
          mask_q <= mask_nxt;
        end
      end
    end
  end

`ifdef PARTIAL_MASK_EN
  logic [WIDTH-1:0] partial_nxt, partial_q;

  always_comb begin
    partial_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      partial_nxt[i] = (pin_cnt_nxt[i] != '0) && (pin_cnt_nxt[i] != STIM_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      partial_q <= '0;
    end else if (step_take && last_stim) begin
      partial_q <= partial_nxt;
    end
  end

  assign mon.res_partial = partial_q;
`endif

  assign mon.busy        = (state == BASE) || (state == ARMED) || (state == SETTLE);
  assign mon.res_valid   = (state == DONE);
  assign mon.res_mask    = mask_q;
  assign mon.res_overrun = (state == DONE) && overrun_q;

endmodule

// File: tb/tb_gpio_response_monitor.sv
// Randomized bench for gpio_response_monitor against a history-based reference model.
module tb_gpio_response_monitor;

  localparam int W    = 36;
  localparam int SYNC = 2;
  localparam int S    = 4;
  localparam int N    = 4;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] gpio_in = '0;

  gpio_response_monitor_if #(.WIDTH(W)) mon_if ();

  gpio_response_monitor #(
    .WIDTH         (W),
    .SYNC_STAGES   (SYNC),
    .SETTLE_CYCLES (S),
    .NUM_STIM      (N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .gpio_in (gpio_in),
    .mon     (mon_if)
  );

  always #10 clk = ~clk;

  // Pin levels seen at every rising edge; the model samples this history.
  logic [W-1:0] hist [0:65535];
  int           ecnt = 0;
  always @(posedge clk) begin
    if (ecnt < 65536) hist[ecnt] = gpio_in;
    ecnt = ecnt + 1;
  end

  int  errors = 0;
  int  checks = 0;
  int  base_e;
  int  cap_e [N];
  bit  busy_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[W-1:0];
  endfunction

  // A pin scores a toggle when its settled level differs from the previous settled level.
  task automatic calc_exp(output logic [W-1:0] m, output logic [W-1:0] p);
    int           c [W];
    logic [W-1:0] prv, smp;
    for (int i = 0; i < W; i++) c[i] = 0;
    prv = hist[base_e + S - SYNC];
    for (int j = 0; j < N; j++) begin
      smp = hist[cap_e[j] + S - SYNC];
      for (int i = 0; i < W; i++)
        if (smp[i] != prv[i] && c[i] < N) c[i]++;
      prv = smp;
    end
    for (int i = 0; i < W; i++) begin
      m[i] = (c[i] == N);
      p[i] = (c[i] != 0) && (c[i] != N);
    end
  endtask

  task automatic do_start(input bit with_stim);
    @(negedge clk);
    mon_if.start      = 1'b1;
    mon_if.stim_pulse = with_stim;
    @(negedge clk);
    mon_if.start      = 1'b0;
    mon_if.stim_pulse = 1'b0;
    base_e   = ecnt - 1;
    busy_bad = (mon_if.busy !== 1'b1);
    repeat (S) begin
      @(negedge clk);
      if (mon_if.busy !== 1'b1 || mon_if.res_valid !== 1'b0) busy_bad = 1'b1;
    end
  endtask

  // Called at a negedge in ARMED; returns at the negedge after the sample edge (+gap).
  task automatic do_stim(input int j, input logic [W-1:0] tog, input int toff,
                         input bit stray, input int gap);
    mon_if.stim_pulse = 1'b1;
    @(negedge clk);
    mon_if.stim_pulse = 1'b0;
    cap_e[j] = ecnt - 1;
    for (int o = 0; o < S; o++) begin
      if (mon_if.busy !== 1'b1 || mon_if.res_valid !== 1'b0) busy_bad = 1'b1;
      if (o == toff) gpio_in = gpio_in ^ tog;
      mon_if.stim_pulse = stray && (o == 1);
      @(negedge clk);
    end
    mon_if.stim_pulse = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic finish_meas(input string tag, input bit exp_ovr, input int rdy_delay);
    logic [W-1:0] em, ep;
    calc_exp(em, ep);
    chk({tag, "_valid"},   mon_if.res_valid, 1);
    chk({tag, "_busy"},    mon_if.busy, 0);
    chk({tag, "_busyspan"}, busy_bad, 0);
    chk({tag, "_mask"},    mon_if.res_mask, em);
    chk({tag, "_overrun"}, mon_if.res_overrun, exp_ovr);
`ifdef PARTIAL_MASK_EN
    chk({tag, "_partial"}, mon_if.res_partial, ep);
`endif
    repeat (rdy_delay) @(negedge clk);
    mon_if.res_ready = 1'b1;
    @(negedge clk);
    mon_if.res_ready = 1'b0;
    chk({tag, "_valid_drop"}, mon_if.res_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] saved, fol;
    bit           stable;
    mon_if.start      = 1'b0;
    mon_if.stim_pulse = 1'b0;
    mon_if.res_ready  = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    mon_if.busy, 0);
    chk("rst_valid",   mon_if.res_valid, 0);
    chk("rst_mask",    mon_if.res_mask, 0);
    chk("rst_overrun", mon_if.res_overrun, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Pins 5 and 9 follow every toggle
    gpio_in = rnd_w();
    do_start(1'b0);
    for (int j = 0; j < N; j++)
      do_stim(j, 36'h220, $urandom_range(0, 1), 1'b0, (j == N-1) ? 0 : $urandom_range(0, 3));
    chk("t1_mask_const", mon_if.res_mask, 36'h220);
    finish_meas("t1", 1'b0, 0);

    // Pin 7 follows only the first two toggles
    gpio_in = rnd_w();
    do_start(1'b0);
    for (int j = 0; j < N; j++)
      do_stim(j, (j < 2) ? 36'h2A0 : 36'h220, 0, 1'b0, (j == N-1) ? 0 : 1);
    chk("t2_mask_const", mon_if.res_mask, 36'h220);
`ifdef PARTIAL_MASK_EN
    chk("t2_partial_const", mon_if.res_partial, 36'h80);
`endif
    finish_meas("t2", 1'b0, 2);

    // Stray stim during SETTLE, plus a stim coinciding with start
    do_start(1'b1);
    for (int j = 0; j < N; j++)
      do_stim(j, 36'h220, 0, j == 1, (j == N-1) ? 0 : 2);
    chk("t3_mask_const", mon_if.res_mask, 36'h220);
    finish_meas("t3", 1'b1, 1);
    do_start(1'b0);
    for (int j = 0; j < N; j++)
      do_stim(j, 36'h1, 0, 1'b0, 0);
    finish_meas("t3b", 1'b0, 0);

    // Result held while res_ready stays low; start must be ignored
    do_start(1'b0);
    for (int j = 0; j < N; j++)
      do_stim(j, rnd_w() | 36'h1, 1, 1'b0, 0);
    saved  = mon_if.res_mask;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mon_if.start = (i == 5);
      @(negedge clk);
      if (mon_if.res_valid !== 1'b1 || mon_if.busy !== 1'b0 || mon_if.res_mask !== saved)
        stable = 1'b0;
    end
    mon_if.start = 1'b0;
    chk("t4_hold_stable", stable, 1);
    finish_meas("t4", 1'b0, 0);

    // Reset in ARMED after two stims
    do_start(1'b0);
    for (int j = 0; j < 2; j++)
      do_stim(j, 36'hF0, 0, 1'b0, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_busy",    mon_if.busy, 0);
    chk("t5_rst_valid",   mon_if.res_valid, 0);
    chk("t5_rst_mask",    mon_if.res_mask, 0);
    chk("t5_rst_overrun", mon_if.res_overrun, 0);
`ifdef PARTIAL_MASK_EN
    chk("t5_rst_partial", mon_if.res_partial, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    do_start(1'b0);
    for (int j = 0; j < N; j++)
      do_stim(j, 36'h3000, 0, 1'b0, 0);
    chk("t5_mask_const", mon_if.res_mask, 36'h3000);
    finish_meas("t5", 1'b0, 0);

    // Pin 3 changes one cycle before each sample point, pin 4 early
    do_start(1'b0);
    for (int j = 0; j < N; j++) begin
      do_stim(j, 36'h10, 0, 1'b0, 0);
    end
    finish_meas("t6_ref", 1'b0, 0);
    do_start(1'b0);
    for (int j = 0; j < N; j++) begin
      gpio_in = gpio_in ^ 36'h10;
      do_stim(j, 36'h8, S - 1, 1'b0, 0);
    end
    chk("t6_late_pin", {62'd0, mon_if.res_mask[4:3]}, 64'h2);
    finish_meas("t6", 1'b0, 0);

    // Randomized measurements
    for (int k = 0; k < 20; k++) begin
      gpio_in = rnd_w();
      fol     = rnd_w();
      do_start($urandom_range(0, 1) == 1);
      for (int j = 0; j < N; j++)
        do_stim(j, fol ^ (rnd_w() & rnd_w() & rnd_w()),
                ($urandom_range(0, 3) == 0) ? S - 1 : $urandom_range(0, 1),
                1'b0, (j == N-1) ? 0 : $urandom_range(0, 3));
      finish_meas("rnd", 1'b0, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
